// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells: the FSM state
// encoding, the default operand width and the bit-counter width helper.
package arith_pkg;

    // Operand width used when an instance does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Control states of the serial datapath.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Width of a counter that must hold 0 .. width-1.
    // Never narrower than one bit, so WIDTH=1 still gets a real register.
    function automatic int cnt_width(input int width);
        if (width <= 1) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage : arith_pkg

// File: rtl/full_adder.sv
// One-bit full adder. It is the addition sibling of the half-subtractor
// cell and carries no state, so it can be reused in any serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the three-input parity; carry is the three-input majority.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. The operands are accepted over a valid/ready
// handshake and added LSB-first, one bit per clock, through one full_adder
// and a carry flop. The sum and carry-out are offered on a second valid/ready
// handshake and stay stable until the consumer takes them.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e            state_q,     state_d;
    logic [WIDTH-1:0]  opa_sr_q,    opa_sr_d;
    logic [WIDTH-1:0]  opb_sr_q,    opb_sr_d;
    logic [WIDTH-1:0]  sum_sr_q,    sum_sr_d;
    logic              c_q,         c_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic              fa_s;
    logic              fa_cout;
    logic [WIDTH-1:0]  sum_shifted;

    // The single adder cell works on the current LSBs and the running carry.
    full_adder u_full_adder (
        .a    (opa_sr_q[0]),
        .b    (opb_sr_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH steps the first
    // (least significant) bit has travelled down to bit 0. A one-bit sum has
    // nothing to shift, so it simply takes the new bit.
    generate
        if (WIDTH == 1) begin : g_sum_one
            assign sum_shifted = fa_s;
        end else begin : g_sum_wide
            assign sum_shifted = {fa_s, sum_sr_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state and datapath decode. The ready/valid flags are derived from
    // the next state so that they come straight out of flops.
    always_comb begin
        state_d  = state_q;
        opa_sr_d = opa_sr_q;
        opb_sr_d = opb_sr_q;
        sum_sr_d = sum_sr_q;
        c_d      = c_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_sr_d = a;
                    opb_sr_d = b;
                    c_d      = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                opa_sr_d = opa_sr_q >> 1;
                opb_sr_d = opb_sr_q >> 1;
                sum_sr_d = sum_shifted;
                c_d      = fa_cout;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // Result is held untouched until the consumer accepts it.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // All state in one register bank; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opa_sr_q    <= '0;
            opb_sr_q    <= '0;
            sum_sr_q    <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_sr_q    <= opa_sr_d;
            opb_sr_q    <= opb_sr_d;
            sum_sr_q    <= sum_sr_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_sr_q;
    assign carry     = c_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1, with a random
// stream at both widths checked against a behavioural a+b model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready, carry;
    logic [7:0] a, b, sum;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, carry1;
    logic [0:0] a1, b1, sum1;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .carry     (carry1)
    );

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One WIDTH=8 operation with out_ready high and hand-computed result.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] es, input logic ec, input string tag);
        int n;
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        check({tag, "_in_ready"}, 33'(in_ready), 33'(1));
        step();
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 33'(n), 33'(8));
        check({tag, "_sum"}, 33'(sum), 33'(es));
        check({tag, "_carry"}, 33'(carry), 33'(ec));
        check({tag, "_busy_ready"}, 33'(in_ready), 33'(0));
        step();
        check({tag, "_post_valid"}, 33'(out_valid), 33'(0));
        check({tag, "_post_ready"}, 33'(in_ready), 33'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pa [4];
        logic [7:0] pb [4];
        logic [7:0] ps [4];
        logic       pc [4];
        int         t_acc [4];
        int         n;
        logic       done;
        logic [7:0] av, bv;
        logic [8:0] exp9;
        logic [0:0] av1, bv1;
        logic [1:0] exp2;

        pa = '{8'h12, 8'h80, 8'h7F, 8'hC3};
        pb = '{8'h34, 8'h80, 8'h01, 8'h5A};
        ps = '{8'h46, 8'h00, 8'h80, 8'h1D};
        pc = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
        step(); step();

        // Reset values.
        check("rst_in_ready", 33'(in_ready), 33'(1));
        check("rst_out_valid", 33'(out_valid), 33'(0));
        check("rst_sum", 33'(sum), 33'(0));
        check("rst_carry", 33'(carry), 33'(0));
        rst_n = 1'b1;
        step();

        // Basic additions, including carry-out and carry flop clearing.
        run_op(8'h0F, 8'h01, 8'h10, 1'b0, "add_0f_01");
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
        run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, "add_ff_ff");
        run_op(8'h00, 8'h00, 8'h00, 1'b0, "add_00_00");

        // Back-pressure: result held while out_ready stays low.
        out_ready = 1'b0;
        a = 8'h35; b = 8'h4A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check("bp_latency", 33'(n), 33'(8));
        for (int j = 0; j < 5; j++) begin
            check("bp_sum", 33'(sum), 33'(8'h7F));
            check("bp_carry", 33'(carry), 33'(0));
            check("bp_in_ready", 33'(in_ready), 33'(0));
            check("bp_out_valid", 33'(out_valid), 33'(1));
            step();
        end
        out_ready = 1'b1;
        check("bp_still_valid", 33'(out_valid), 33'(1));
        step();
        check("bp_release_valid", 33'(out_valid), 33'(0));
        check("bp_release_ready", 33'(in_ready), 33'(1));

        // Reset in the middle of SHIFT.
        a = 8'hAA; b = 8'h55; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("mid_in_ready", 33'(in_ready), 33'(0));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 33'(out_valid), 33'(0));
        check("mid_rst_sum", 33'(sum), 33'(0));
        check("mid_rst_carry", 33'(carry), 33'(0));
        check("mid_rst_ready", 33'(in_ready), 33'(1));
        a = 8'h77; b = 8'h11; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ignore_valid", 33'(in_ready), 33'(1));
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        run_op(8'h01, 8'h02, 8'h03, 1'b0, "post_rst");

        // Back-to-back with in_valid held high.
        out_ready = 1'b1;
        a = pa[0]; b = pb[0]; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("b2b_accept_ready", 33'(in_ready), 33'(1));
            step();
            t_acc[i] = cyc;
            if (i < 3) begin
                a = pa[i+1]; b = pb[i+1];
            end else begin
                in_valid = 1'b0;
            end
            n = 0;
            while (!out_valid && n < 40) begin
                check("b2b_busy_ready", 33'(in_ready), 33'(0));
                step();
                n++;
            end
            check("b2b_latency", 33'(n), 33'(8));
            check("b2b_sum", 33'(sum), 33'(ps[i]));
            check("b2b_carry", 33'(carry), 33'(pc[i]));
            step();
            if (i > 0) begin
                check("b2b_spacing", 33'(t_acc[i] - t_acc[i-1]), 33'(10));
            end
        end

        // WIDTH=1 directed: one SHIFT cycle.
        a1 = 1'b1; b1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b1;
        check("w1_in_ready", 33'(in_ready1), 33'(1));
        step();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            step();
            n++;
        end
        check("w1_latency", 33'(n), 33'(1));
        check("w1_sum", 33'(sum1), 33'(0));
        check("w1_carry", 33'(carry1), 33'(1));
        step();
        check("w1_post_ready", 33'(in_ready1), 33'(1));

        // Random stream at WIDTH=8 with random back-pressure.
        for (int k = 0; k < 1000; k++) begin
            av = 8'($urandom); bv = 8'($urandom);
            exp9 = {1'b0, av} + {1'b0, bv};
            a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
            step();
            in_valid = 1'b0;
            n = 0; done = 1'b0;
            while (!done && n < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check("rnd8_result", 33'({carry, sum}), 33'(exp9));
                    done = 1'b1;
                end else begin
                    n++;
                end
                step();
            end
            if (!done) check("rnd8_timeout", 33'(done), 33'(1));
        end

        // Random stream at WIDTH=1 with random back-pressure.
        for (int k = 0; k < 1000; k++) begin
            av1 = 1'($urandom); bv1 = 1'($urandom);
            exp2 = {1'b0, av1} + {1'b0, bv1};
            a1 = av1; b1 = bv1; in_valid1 = 1'b1; out_ready1 = 1'b0;
            step();
            in_valid1 = 1'b0;
            n = 0; done = 1'b0;
            while (!done && n < 200) begin
                out_ready1 = 1'($urandom_range(0, 1));
                if (out_valid1 && out_ready1) begin
                    check("rnd1_result", 33'({carry1, sum1}), 33'(exp2));
                    done = 1'b1;
                end else begin
                    n++;
                end
                step();
            end
            if (!done) check("rnd1_timeout", 33'(done), 33'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: the addition counterpart to the team's subtractor cells.
- Accepts two operands over a valid/ready handshake and adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flop.
- Presents sum and carry-out over a second valid/ready handshake.
- Used as a low-area arithmetic unit in the combinational/sequential primitives library, and as a DUT for serial-datapath verification.

Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  augend, sampled on input handshake
- b  input  WIDTH  addend, sampled on input handshake
- out_valid  output  1  sum/carry valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a+b modulo 2^WIDTH
- carry  output  1  carry-out of a+b (bit WIDTH)

Behaviour:
- Reset:
  - rst_n low asynchronously forces state=IDLE, out_valid=0, sum=0, carry=0, bit counter=0, shift registers=0.
  - in_ready=1 (IDLE decode), but in_valid is ignored while rst_n is low.
  - Reset mid-operation discards the operation; no partial result is ever presented.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready at an edge: latch a->opa_sr, b->opb_sr, clear carry flop and counter, go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each edge: s = opa_sr[0]^opb_sr[0]^c; c <= majority(opa_sr[0], opb_sr[0], c).
  - Shift opa_sr/opb_sr right by 1; shift s into sum_sr at MSB (right shift); counter++.
  - On the edge where counter reaches WIDTH-1, go to DONE with the final sum and carry registered.
- DONE:
  - out_valid=1; sum/carry held stable until out_ready.
  - On out_valid & out_ready: go to IDLE. sum/carry keep their last value; they are meaningful only while out_valid=1.
- Latency and throughput:
  - Input handshake at edge k -> out_valid rises after edge k+WIDTH.
  - One operation per WIDTH+2 cycles minimum, with out_ready tied high.
- Back-pressure: out_ready low in DONE holds state, sum and carry indefinitely; in_ready stays 0.
- Simultaneous events: in_ready and out_valid are never both 1, so no accept/deliver overlap. a/b changing outside the handshake edge has no effect.
- WIDTH=1: exactly one SHIFT cycle; counter width is max(1, clog2(WIDTH)).
- Arithmetic: {carry, sum} == a + b as unsigned WIDTH+1-bit value, for all inputs.

Decomposition:
- Shared package `arith_pkg`:
  - state enum (IDLE/SHIFT/DONE, 2-bit encoding)
  - counter-width function/constant derived from WIDTH
  - default WIDTH constant
- Sub-module `full_adder` (combinational a, b, cin -> s, cout), instanced once for the per-bit step. It is the natural sibling of the existing half-subtractor cell and is reusable.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, out_ready=1 -> out_valid rises 8 cycles after handshake; sum=8'h10, carry=0; in_ready=1 one cycle after delivery.
- a=8'hFF, b=8'h01 -> sum=8'h00, carry=1; then a=8'hFF, b=8'hFF -> sum=8'hFE, carry=1; a=0, b=0 -> sum=0, carry=0 (carry flop cleared between ops).
- Back-pressure: a=8'h35, b=8'h4A, out_ready low for 5 cycles after out_valid -> sum=8'h7F, carry=0 held stable all 5 cycles; in_ready=0 throughout; release -> IDLE next edge.
- Reset mid-SHIFT: assert rst_n=0 three cycles after handshake of a=8'hAA, b=8'h55 -> out_valid=0, sum=0, carry=0 immediately (async); after release, a=8'h01, b=8'h02 -> sum=8'h03 with no residue.
- Back-to-back: in_valid held high with 4 different operand pairs, out_ready=1 -> each accepted in IDLE only, results in order, WIDTH+2 cycle spacing.
- Random: 1000 random a/b at WIDTH=8 and WIDTH=1, random out_ready -> scoreboard {carry, sum} == a+b every delivery.
